// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and IR decode.
// JTAG_INTEST_EN selects whether opcode 10 decodes as INTEST or falls back to BYPASS.
package jtag_pkg;

    localparam int IR_W = 2;

    localparam logic [IR_W-1:0] OP_EXTEST  = 2'b00;
    localparam logic [IR_W-1:0] OP_SAMPLE  = 2'b01;
    localparam logic [IR_W-1:0] OP_INTEST  = 2'b10;
    localparam logic [IR_W-1:0] OP_BYPASS  = 2'b11;
    localparam logic [IR_W-1:0] IR_CAPTURE = 2'b01;

    typedef enum logic [3:0] {
        ST_TLR       = 4'd0,
        ST_RTI       = 4'd1,
        ST_SEL_DR    = 4'd2,
        ST_CAP_DR    = 4'd3,
        ST_SHIFT_DR  = 4'd4,
        ST_EXIT1_DR  = 4'd5,
        ST_PAUSE_DR  = 4'd6,
        ST_EXIT2_DR  = 4'd7,
        ST_UPDATE_DR = 4'd8,
        ST_SEL_IR    = 4'd9,
        ST_CAP_IR    = 4'd10,
        ST_SHIFT_IR  = 4'd11,
        ST_EXIT1_IR  = 4'd12,
        ST_PAUSE_IR  = 4'd13,
        ST_EXIT2_IR  = 4'd14,
        ST_UPDATE_IR = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {
        INSTR_EXTEST = 2'd0,
        INSTR_SAMPLE = 2'd1,
        INSTR_INTEST = 2'd2,
        INSTR_BYPASS = 2'd3
    } instr_t;

    // Unimplemented opcodes must fall back to BYPASS so the pins stay transparent.
    function automatic instr_t decode_ir(input logic [IR_W-1:0] ir);
        instr_t instr;
        case (ir)
            OP_EXTEST: instr = INSTR_EXTEST;
            OP_SAMPLE: instr = INSTR_SAMPLE;
`ifdef JTAG_INTEST_EN
            OP_INTEST: instr = INSTR_INTEST;
`else
            OP_INTEST: instr = INSTR_BYPASS;
`endif
            default:   instr = INSTR_BYPASS;
        endcase
        return instr;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller with decoded per-state strobes for the DR/IR datapath.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    output logic tlr_s,
    output logic capture_dr_s,
    output logic shift_dr_s,
    output logic update_dr_s,
    output logic capture_ir_s,
    output logic shift_ir_s,
    output logic update_ir_s
);

    tap_state_t state_r;
    tap_state_t state_next_s;

    // TAP state register
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_r <= ST_TLR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Standard TMS-driven transitions
    always_comb begin
        state_next_s = ST_TLR;
        case (state_r)
            ST_TLR:       state_next_s = tms ? ST_TLR       : ST_RTI;
            ST_RTI:       state_next_s = tms ? ST_SEL_DR    : ST_RTI;
            ST_SEL_DR:    state_next_s = tms ? ST_SEL_IR    : ST_CAP_DR;
            ST_CAP_DR:    state_next_s = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:  state_next_s = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:  state_next_s = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:  state_next_s = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:  state_next_s = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR: state_next_s = tms ? ST_SEL_DR    : ST_RTI;
            ST_SEL_IR:    state_next_s = tms ? ST_TLR       : ST_CAP_IR;
            ST_CAP_IR:    state_next_s = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:  state_next_s = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:  state_next_s = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:  state_next_s = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:  state_next_s = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR: state_next_s = tms ? ST_SEL_DR    : ST_RTI;
            default:      state_next_s = ST_TLR;
        endcase
    end

    // Strobes are "currently in state"; the datapath acts on the rising edge leaving it
    always_comb begin
        tlr_s        = 1'b0;
        capture_dr_s = 1'b0;
        shift_dr_s   = 1'b0;
        update_dr_s  = 1'b0;
        capture_ir_s = 1'b0;
        shift_ir_s   = 1'b0;
        update_ir_s  = 1'b0;
        case (state_r)
            ST_TLR:       tlr_s        = 1'b1;
            ST_CAP_DR:    capture_dr_s = 1'b1;
            ST_SHIFT_DR:  shift_dr_s   = 1'b1;
            ST_UPDATE_DR: update_dr_s  = 1'b1;
            ST_CAP_IR:    capture_ir_s = 1'b1;
            ST_SHIFT_IR:  shift_ir_s   = 1'b1;
            ST_UPDATE_IR: update_ir_s  = 1'b1;
            default:      tlr_s        = 1'b0;
        endcase
    end

endmodule

// File: rtl/jtag_bscan_tap.sv
// TAP controller plus boundary-scan register around an N-bit adder core.
// Define JTAG_INTEST_EN to implement INTEST (opcode 10); otherwise it decodes as BYPASS.
module jtag_bscan_tap
    import jtag_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         TCK,
    input  logic         TRST_N,
    input  logic         TMS,
    input  logic         TDI,
    output logic         TDO,
    input  logic [N-1:0] sys_pin_a,
    input  logic [N-1:0] sys_pin_b,
    input  logic         sys_pin_cin,
    input  logic         sys_pin_sel,
    input  logic [N-1:0] module_pin_sum,
    input  logic         module_pin_co,
    output logic [N-1:0] module_pin_a,
    output logic [N-1:0] module_pin_b,
    output logic         module_pin_cin,
    output logic         module_pin_sel,
    output logic [N-1:0] sys_pin_sum,
    output logic         sys_pin_co
);

    localparam int L = 3 * N + 3;
    // Only the cells that can drive a pin need an update latch.
`ifdef JTAG_INTEST_EN
    localparam int UPD_LO = 0;
`else
    localparam int UPD_LO = 2 * N + 2;
`endif

    logic            srst_s;
    logic            capture_dr_s;
    logic            shift_dr_s;
    logic            update_dr_s;
    logic            capture_ir_s;
    logic            shift_ir_s;
    logic            update_ir_s;
    instr_t          instr_s;
    logic            bsr_sel_s;
    logic [IR_W-1:0] ir_shift_r;
    logic [IR_W-1:0] ir_r;
    logic [L-1:0]    bsr_r;
    logic [L-1:UPD_LO] update_r;
    logic            bypass_r;
    logic            tdo_r;

    jtag_tap_fsm u_fsm (
        .tck          (TCK),
        .trst_n       (TRST_N),
        .tms          (TMS),
        .tlr_s        (srst_s),
        .capture_dr_s (capture_dr_s),
        .shift_dr_s   (shift_dr_s),
        .update_dr_s  (update_dr_s),
        .capture_ir_s (capture_ir_s),
        .shift_ir_s   (shift_ir_s),
        .update_ir_s  (update_ir_s)
    );

    assign instr_s   = decode_ir(ir_r);
    assign bsr_sel_s = (instr_s != INSTR_BYPASS);

    // Instruction shift register and active instruction
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_shift_r <= IR_CAPTURE;
            ir_r       <= OP_BYPASS;
        end else if (srst_s) begin
            ir_r       <= OP_BYPASS;
        end else if (capture_ir_s) begin
            ir_shift_r <= IR_CAPTURE;
        end else if (shift_ir_s) begin
            ir_shift_r <= {TDI, ir_shift_r[IR_W-1:1]};
        end else if (update_ir_s) begin
            ir_r       <= ir_shift_r;
        end
    end

    // Boundary-scan shift chain and bypass bit
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bsr_r    <= '0;
            bypass_r <= 1'b0;
        end else if (capture_dr_s) begin
            if (bsr_sel_s) begin
                bsr_r <= {module_pin_co, module_pin_sum, sys_pin_sel, sys_pin_cin,
                          sys_pin_b, sys_pin_a};
            end else begin
                bypass_r <= 1'b0;
            end
        end else if (shift_dr_s) begin
            if (bsr_sel_s) begin
                bsr_r <= {TDI, bsr_r[L-1:1]};
            end else begin
                bypass_r <= TDI;
            end
        end
    end

    // Parallel update latch, cleared in Test-Logic-Reset so an aborted scan never lands
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            update_r <= '0;
        end else if (srst_s) begin
            update_r <= '0;
        end else if (update_dr_s && bsr_sel_s) begin
            update_r <= bsr_r[L-1:UPD_LO];
        end
    end

    // TDO launches on the falling edge so the receiver samples it cleanly on the next rise
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo_r <= 1'b0;
        end else if (shift_ir_s) begin
            tdo_r <= ir_shift_r[0];
        end else if (shift_dr_s) begin
            tdo_r <= bsr_sel_s ? bsr_r[0] : bypass_r;
        end else begin
            tdo_r <= 1'b0;
        end
    end

    assign TDO = tdo_r;

    // Pin muxing between system pins, core pins and the update latch
    always_comb begin
        module_pin_a   = sys_pin_a;
        module_pin_b   = sys_pin_b;
        module_pin_cin = sys_pin_cin;
        module_pin_sel = sys_pin_sel;
        sys_pin_sum    = module_pin_sum;
        sys_pin_co     = module_pin_co;
        case (instr_s)
            INSTR_EXTEST: begin
                sys_pin_sum = update_r[3*N+1:2*N+2];
                sys_pin_co  = update_r[3*N+2];
            end
`ifdef JTAG_INTEST_EN
            INSTR_INTEST: begin
                module_pin_a   = update_r[N-1:0];
                module_pin_b   = update_r[2*N-1:N];
                module_pin_cin = update_r[2*N];
                module_pin_sel = update_r[2*N+1];
                sys_pin_sum    = update_r[3*N+1:2*N+2];
                sys_pin_co     = update_r[3*N+2];
            end
`endif
            default: begin
                sys_pin_co = module_pin_co;
            end
        endcase
    end

endmodule

// File: tb/tb_jtag_bscan_tap.sv
// Randomized bench for jtag_bscan_tap against a scan-level reference model.
module tb_jtag_bscan_tap;

    localparam int N = 16;
    localparam int L = 3 * N + 3;

    logic         TCK = 1'b0;
    logic         TRST_N;
    logic         TMS;
    logic         TDI;
    logic         TDO;
    logic [N-1:0] sys_pin_a;
    logic [N-1:0] sys_pin_b;
    logic         sys_pin_cin;
    logic         sys_pin_sel;
    logic [N-1:0] module_pin_sum;
    logic         module_pin_co;
    logic [N-1:0] module_pin_a;
    logic [N-1:0] module_pin_b;
    logic         module_pin_cin;
    logic         module_pin_sel;
    logic [N-1:0] sys_pin_sum;
    logic         sys_pin_co;

    int checks = 0;
    int errors = 0;

    // Reference model: active opcode and what the last completed BSR update latched
    logic [1:0]   model_ir;
    logic [L-1:0] model_upd;

    jtag_bscan_tap #(.N(N)) dut (
        .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .sys_pin_a(sys_pin_a), .sys_pin_b(sys_pin_b),
        .sys_pin_cin(sys_pin_cin), .sys_pin_sel(sys_pin_sel),
        .module_pin_sum(module_pin_sum), .module_pin_co(module_pin_co),
        .module_pin_a(module_pin_a), .module_pin_b(module_pin_b),
        .module_pin_cin(module_pin_cin), .module_pin_sel(module_pin_sel),
        .sys_pin_sum(sys_pin_sum), .sys_pin_co(sys_pin_co)
    );

    always #5 TCK = ~TCK;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One TCK: drive TMS/TDI in the low phase, read TDO launched by the previous fall
    task automatic step(input logic tms, input logic tdi, output logic tdo);
        TMS = tms;
        TDI = tdi;
        tdo = TDO;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    function automatic logic [1:0] eff_op(input logic [1:0] op);
`ifdef JTAG_INTEST_EN
        return op;
`else
        return (op == 2'b10) ? 2'b11 : op;
`endif
    endfunction

    function automatic logic [L-1:0] capture_vec();
        return {module_pin_co, module_pin_sum, sys_pin_sel, sys_pin_cin, sys_pin_b, sys_pin_a};
    endfunction

    task automatic check_pins(input string tag);
        logic [1:0]      op;
        logic [2*N+1:0]  exp_core;
        logic [N:0]      exp_sys;
        op       = eff_op(model_ir);
        exp_core = {sys_pin_sel, sys_pin_cin, sys_pin_b, sys_pin_a};
        exp_sys  = {module_pin_co, module_pin_sum};
        if (op == 2'b10) exp_core = model_upd[2*N+1:0];
        if (op == 2'b00 || op == 2'b10) exp_sys = model_upd[L-1:2*N+2];
        check({tag, "_core"}, 64'({module_pin_sel, module_pin_cin, module_pin_b, module_pin_a}),
              64'(exp_core));
        check({tag, "_sys"}, 64'({sys_pin_co, sys_pin_sum}), 64'(exp_sys));
    endtask

    // RTI -> Shift-IR, shift opcode LSB first, Update-IR -> RTI
    task automatic ir_scan(input logic [1:0] op, output logic [1:0] cap);
        logic d;
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, op[0], cap[0]);
        step(1'b1, op[1], cap[1]);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        model_ir = op;
    endtask

    task automatic enter_shift_dr();
        logic d;
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    // RTI -> Shift-DR, len shifts, Update-DR -> RTI
    task automatic dr_scan(input logic [L-1:0] din, input int len, output logic [L-1:0] dout);
        logic d;
        dout = '0;
        enter_shift_dr();
        for (int i = 0; i < len; i++) step(i == len - 1, din[i], dout[i]);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    task automatic abort_scan(input int k);
        logic d;
        enter_shift_dr();
        for (int i = 0; i < k; i++) step(1'b0, 1'($urandom), d);
        repeat (5) step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        model_ir  = 2'b11;
        model_upd = '0;
    endtask

    function automatic logic [L-1:0] bypass_exp(input logic [L-1:0] din, input int len);
        logic [L-1:0] e;
        e = '0;
        for (int i = 1; i < len; i++) e[i] = din[i-1];
        return e;
    endfunction

    function automatic logic [L-1:0] rand_vec();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[L-1:0];
    endfunction

    task automatic bypass_check(input string tag);
        logic [L-1:0] din;
        logic [L-1:0] dout;
        int len;
        len = $urandom_range(2, 16);
        din = rand_vec();
        dr_scan(din, len, dout);
        check(tag, 64'(dout), 64'(bypass_exp(din, len)));
    endtask

    initial begin
        logic [1:0]   cap;
        logic [L-1:0] din;
        logic [L-1:0] dout;
        logic         d;
        logic [1:0]   op;

        TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0;
        sys_pin_a = 16'h0000; sys_pin_b = 16'hFFFF; sys_pin_cin = 1'b0; sys_pin_sel = 1'b1;
        module_pin_sum = 16'hAAAA; module_pin_co = 1'b1;
        model_ir = 2'b11; model_upd = '0;
        repeat (3) @(negedge TCK);
        #1;
        check("rst_tdo", 64'(TDO), 64'(1'b0));
        check("rst_mod_a", 64'(module_pin_a), 64'(16'h0000));
        check("rst_mod_b", 64'(module_pin_b), 64'(16'hFFFF));
        check("rst_sum", 64'({sys_pin_co, sys_pin_sum}), 64'({1'b1, 16'hAAAA}));
        check_pins("rst");
        TRST_N = 1'b1;
        step(1'b0, 1'b0, d);

        // SAMPLE loaded, then abandoned from Shift-DR via five TMS=1
        ir_scan(2'b01, cap);
        check("ir_cap", 64'(cap), 64'(2'b01));
        abort_scan(3);
        bypass_check("tlr_bypass");

        // Directed SAMPLE capture of the common pin pattern
        ir_scan(2'b01, cap);
        din = rand_vec();
        dr_scan(din, L, dout);
        check("sample_stream", 64'(dout), 64'({1'b1, 16'hAAAA, 1'b1, 1'b0, 16'hFFFF, 16'h0000}));
        model_upd = din;
        check_pins("sample");

        // Preload sum=5555 co=0 then switch to EXTEST
        din = rand_vec();
        din[L-1:2*N+2] = {1'b0, 16'h5555};
        dr_scan(din, L, dout);
        model_upd = din;
        ir_scan(2'b00, cap);
        check("extest_sum", 64'({sys_pin_co, sys_pin_sum}), 64'({1'b0, 16'h5555}));
        check("extest_b", 64'(module_pin_b), 64'(16'hFFFF));
        check_pins("extest");

        for (int it = 0; it < 30; it++) begin
            sys_pin_a = N'($urandom); sys_pin_b = N'($urandom);
            sys_pin_cin = 1'($urandom); sys_pin_sel = 1'($urandom);
            module_pin_sum = N'($urandom); module_pin_co = 1'($urandom);
            op = 2'($urandom_range(0, 3));
            ir_scan(op, cap);
            check("rnd_ir_cap", 64'(cap), 64'(2'b01));
            check_pins("rnd_ir");
            if ($urandom_range(0, 4) == 0) begin
                abort_scan($urandom_range(0, 8));
            end else if (eff_op(op) != 2'b11) begin
                din = rand_vec();
                dr_scan(din, L, dout);
                check("rnd_bsr", 64'(dout), 64'(capture_vec()));
                model_upd = din;
            end else begin
                bypass_check("rnd_bypass");
            end
            check_pins("rnd");
        end

        // Asynchronous reset in the middle of a BSR shift
        ir_scan(2'b00, cap);
        enter_shift_dr();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, d);
        TRST_N = 1'b0;
        #1;
        model_ir = 2'b11; model_upd = '0;
        check("trst_tdo", 64'(TDO), 64'(1'b0));
        check_pins("trst");
        #1;
        TRST_N = 1'b1;
        step(1'b0, 1'b0, d);
        bypass_check("trst_bypass");
        check_pins("trst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
